// File: rtl/key_pkg.sv
// key_pkg
//   Shared definitions for the key-to-mode control path: the press-tracking
//   state encoding, the modulation mode encodings consumed by the modulator
//   top, and the default timing constants for a 50 MHz system clock.
package key_pkg;

  // Press tracking states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_state_t;

  // Modulation mode encodings, stepped in this order by short presses.
  localparam int MODE_2FSK  = 0;
  localparam int MODE_2PSK  = 1;
  localparam int MODE_2DPSK = 2;
  localparam int MODE_QPSK  = 3;

  // Default timing constants (1 ms tick at 50 MHz).
  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_TICK_DIV     = 50_000;
  localparam int DEF_LONG_TICKS   = 800;
  localparam int DEF_REPEAT_TICKS = 300;
  localparam int DEF_NUM_MODES    = MODE_QPSK + 1;

endpackage

// File: rtl/key_mode_ctrl_if.sv
// key_mode_ctrl_if
//   Bundles the debounced key input and the control outputs of the key mode
//   controller.
//   Signals:
//     clear_key   debounced key level (into the controller)
//     mode        current modulation mode, 0..NUM_MODES-1
//     run_en      transmit enable level
//     short_pulse one-cycle pulse per accepted short press / repeat step
//     long_pulse  one-cycle pulse when a hold reaches the long threshold
//     key_busy    high while a press is being tracked
//   Modports:
//     master  the controller (drives the outputs, reads clear_key)
//     slave   the debouncer/modulator side
interface key_mode_ctrl_if import key_pkg::*; #(
  parameter int NUM_MODES = DEF_NUM_MODES
);
  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic              clear_key;
  logic [MODE_W-1:0] mode;
  logic              run_en;
  logic              short_pulse;
  logic              long_pulse;
  logic              key_busy;

  modport master (
    input  clear_key,
    output mode,
    output run_en,
    output short_pulse,
    output long_pulse,
    output key_busy
  );

  modport slave (
    output clear_key,
    input  mode,
    input  run_en,
    input  short_pulse,
    input  long_pulse,
    input  key_busy
  );

endinterface

// File: rtl/key_tick_gen.sv
// key_tick_gen
//   Free-running clock divider producing a one-cycle timing tick every
//   TICK_DIV clocks. The counter runs 0..TICK_DIV-1 and `tick` is high while
//   it sits at TICK_DIV-1, after which it wraps to 0. It is never restarted by
//   external events, so consumers see +/-1 tick quantisation.
//   Ports:
//     clk   system clock
//     rst   asynchronous active-high reset (counter to 0)
//     tick  one-cycle timing strobe
module key_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_cfg_error
    $error("key_tick_gen: TICK_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Turns debounced key presses into control events for the modulator top.
//   A short press steps the modulation mode (2FSK/2PSK/2DPSK/QPSK, wrapping);
//   a hold reaching LONG_TICKS ticks toggles the transmit run enable while the
//   key is still down. Events are one-cycle pulses; mode and run_en are held.
//   Optional feature (macro KEY_AUTOREPEAT_EN): while held past the long
//   threshold, every REPEAT_TICKS ticks a repeat step is issued exactly like a
//   short press. Without the macro the long-held state only waits for release.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset (all outputs 0, state IDLE)
//     bus  key_mode_ctrl_if.master: clear_key in; mode, run_en, short_pulse,
//          long_pulse, key_busy out
module key_mode_ctrl import key_pkg::*; #(
  parameter int   CLK_HZ       = DEF_CLK_HZ,
  parameter int   TICK_DIV     = DEF_TICK_DIV,
  parameter int   LONG_TICKS   = DEF_LONG_TICKS,
  parameter int   REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int   NUM_MODES    = DEF_NUM_MODES,
  parameter logic PRESS_LEVEL  = 1'b1
) (
  input logic           clk,
  input logic           rst,
  key_mode_ctrl_if.master bus
);

  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  // CLK_HZ only documents the intended clock; it takes part in the sanity
  // check so a nonsensical configuration is caught at elaboration.
  if (CLK_HZ < 1 || TICK_DIV < 2 || LONG_TICKS < 2 || REPEAT_TICKS < 1 ||
      NUM_MODES < 2) begin : g_cfg_error
    $error("key_mode_ctrl: invalid parameter set");
  end

  // Modulo-NUM_MODES increment; codes NUM_MODES..2^MODE_W-1 never appear.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    if (m == MODE_LAST) begin
      return '0;
    end
    return m + MODE_W'(1);
  endfunction

  logic              key_d;
  logic              key_down;
  logic              press_edge;
  logic              release_edge;
  logic              tick;
  key_state_t        state;
  key_state_t        state_nxt;
  logic [HOLD_W-1:0] hold;
  logic              do_short;
  logic              do_long;
  logic [MODE_W-1:0] mode_q;
  logic              run_q;
  logic              short_q;
  logic              long_q;

  key_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Edge detection against the previous-cycle key level. key_d resets to the
  // released level so a key still held across reset yields a fresh press.
  assign key_down     = (bus.clear_key == PRESS_LEVEL);
  assign press_edge   = key_down && (key_d != PRESS_LEVEL);
  assign release_edge = !key_down && (key_d == PRESS_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_d <= ~PRESS_LEVEL;
    end else begin
      key_d <= bus.clear_key;
    end
  end

  // Hold length in ticks since the press edge, saturating at LONG_TICKS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (press_edge) begin
      hold <= '0;
    end else if (tick && key_down && (hold != HOLD_MAX)) begin
      hold <= hold + HOLD_W'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] rep;
  logic             rep_hit;

  // Ticks since the long event (or the last repeat step).
  assign rep_hit = tick && (rep == REP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep <= '0;
    end else if (do_long) begin
      rep <= '0;
    end else if ((state == LONG_HELD) && tick) begin
      rep <= rep_hit ? '0 : (rep + REP_W'(1));
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Release is examined before the long-threshold tick so a release landing
  // on that tick still counts as a short press.
  always_comb begin
    state_nxt = state;
    do_short  = 1'b0;
    do_long   = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_edge) begin
          state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (release_edge) begin
          state_nxt = IDLE;
          do_short  = 1'b1;
        end else if (tick && (hold == HOLD_LAST)) begin
          state_nxt = LONG_HELD;
          do_long   = 1'b1;
        end
      end
      LONG_HELD: begin
        if (release_edge) begin
          state_nxt = IDLE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rep_hit) begin
          do_short = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered events: pulses and the mode/run updates land together one
  // cycle after the deciding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_W'(MODE_2FSK);
      run_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      short_q <= do_short;
      long_q  <= do_long;
      if (do_short) begin
        mode_q <= next_mode(mode_q);
      end
      if (do_long) begin
        run_q <= ~run_q;
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.run_en      = run_q;
  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
  assign bus.key_busy    = (state != IDLE);

endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl
//   Directed bench for key_mode_ctrl with TICK_DIV=4, LONG_TICKS=10,
//   REPEAT_TICKS=5, NUM_MODES=4. Build with KEY_AUTOREPEAT_EN to cover the
//   repeat steps; expectations adapt to the build.
module tb_key_mode_ctrl;
  import key_pkg::*;

  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 10;
  localparam int REPEAT_TICKS = 5;
  localparam int NUM_MODES    = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  int   exp_mode;

  always #5 clk = ~clk;

  key_mode_ctrl_if #(.NUM_MODES(NUM_MODES)) bus ();

  key_mode_ctrl #(
    .CLK_HZ       (1000),
    .TICK_DIV     (TICK_DIV),
    .LONG_TICKS   (LONG_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS),
    .NUM_MODES    (NUM_MODES),
    .PRESS_LEVEL  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Edges since reset released; a tick is consumed on edges where cyc%4==0.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge on which a tick was consumed.
  task automatic align();
    for (int i = 0; i < TICK_DIV; i++) begin
      if (cyc % TICK_DIV == 0) break;
      step();
    end
  endtask

  // Press for hold_cyc edges, release, then watch three more edges.
  // Pulse positions are edge indices relative to the press (first edge = 1).
  task automatic press(input int hold_cyc, output int n_short, output int n_long,
                       output int first_short, output int first_long,
                       output int busy1, output int n_both);
    n_short = 0; n_long = 0; first_short = -1; first_long = -1;
    busy1 = -1; n_both = 0;
    bus.clear_key = 1'b1;
    for (int i = 1; i <= hold_cyc + 3; i++) begin
      if (i == hold_cyc + 1) bus.clear_key = 1'b0;
      step();
      if (i == 1) busy1 = int'(bus.key_busy);
      if (bus.short_pulse) begin
        n_short++;
        if (first_short < 0) first_short = i;
      end
      if (bus.long_pulse) begin
        n_long++;
        if (first_long < 0) first_long = i;
      end
      if (bus.short_pulse && bus.long_pulse) n_both++;
    end
  endtask

  initial begin
    int ns, nl, fs, fl, b1, nb, total;
    int wrap_exp[3];
    wrap_exp = '{MODE_2DPSK, MODE_QPSK, MODE_2FSK};

    // Reset state
    bus.clear_key = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode",  int'(bus.mode), 0);
    check("rst_run",   int'(bus.run_en), 0);
    check("rst_short", int'(bus.short_pulse), 0);
    check("rst_long",  int'(bus.long_pulse), 0);
    check("rst_busy",  int'(bus.key_busy), 0);
    rst = 1'b0;

    // Short press: 20 clocks held, pulse on the edge after release
    align();
    press(20, ns, nl, fs, fl, b1, nb);
    check("short_busy1", b1, 1);
    check("short_cnt",   ns, 1);
    check("short_lat",   fs, 21);
    check("short_long",  nl, 0);
    check("short_mode",  int'(bus.mode), MODE_2PSK);
    check("short_run",   int'(bus.run_en), 0);
    check("short_busy_end", int'(bus.key_busy), 0);

    // Wrap: three more short presses walk 2,3,0
    total = ns;
    for (int k = 0; k < 3; k++) begin
      press(8, ns, nl, fs, fl, b1, nb);
      total += ns;
      check($sformatf("wrap_mode%0d", k), int'(bus.mode), wrap_exp[k]);
    end
    check("wrap_total", total, 4);
    exp_mode = 0;

    // Long press: pulse at the 10th tick while still held, run_en toggles
    align();
    press(60, ns, nl, fs, fl, b1, nb);
    exp_mode = (exp_mode + AR) % NUM_MODES;
    check("long1_cnt",   nl, 1);
    check("long1_lat",   fl, 40);
    check("long1_short", ns, AR);
    check("long1_both",  nb, 0);
    check("long1_run",   int'(bus.run_en), 1);
    check("long1_mode",  int'(bus.mode), exp_mode);

    align();
    press(60, ns, nl, fs, fl, b1, nb);
    exp_mode = (exp_mode + AR) % NUM_MODES;
    check("long2_cnt",  nl, 1);
    check("long2_run",  int'(bus.run_en), 0);
    check("long2_mode", int'(bus.mode), exp_mode);

    // Boundary: release lands on the 10th tick -> short press wins
    align();
    press(39, ns, nl, fs, fl, b1, nb);
    exp_mode = (exp_mode + 1) % NUM_MODES;
    check("bound_short", ns, 1);
    check("bound_lat",   fs, 40);
    check("bound_long",  nl, 0);
    check("bound_run",   int'(bus.run_en), 0);
    check("bound_mode",  int'(bus.mode), exp_mode);

    // 100-tick hold: repeat steps at ticks 15,20..100 only with auto-repeat
    align();
    press(400, ns, nl, fs, fl, b1, nb);
    exp_mode = (exp_mode + 18 * AR) % NUM_MODES;
    check("hold_long",  nl, 1);
    check("hold_steps", ns, 18 * AR);
    check("hold_both",  nb, 0);
    check("hold_run",   int'(bus.run_en), 1);
    check("hold_mode",  int'(bus.mode), exp_mode);

    // Reset mid-press, key still held through and after reset
    bus.clear_key = 1'b1;
    repeat (5) step();
    check("mid_busy", int'(bus.key_busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_mode",  int'(bus.mode), 0);
    check("mid_rst_run",   int'(bus.run_en), 0);
    check("mid_rst_short", int'(bus.short_pulse), 0);
    check("mid_rst_long",  int'(bus.long_pulse), 0);
    check("mid_rst_busy",  int'(bus.key_busy), 0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy0", int'(bus.key_busy), 0);
    press(5, ns, nl, fs, fl, b1, nb);
    check("post_rst_busy1", b1, 1);
    check("post_rst_short", ns, 1);
    check("post_rst_long",  nl, 0);
    check("post_rst_mode",  int'(bus.mode), MODE_2PSK);
    check("post_rst_run",   int'(bus.run_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
